// File: rtl/lbp_pkg.sv
// Shared types and defaults for the LBP memory responder: FSM states, image geometry, border test.
package lbp_pkg;

  localparam int unsigned LBP_IMG_W  = 128;
  localparam int unsigned LBP_IMG_H  = 128;
  localparam int unsigned LBP_ADDR_W = 14;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } lbp_state_e;

  // Raster address lies in row 0, last row, column 0 or last column.
  function automatic logic is_border(input int unsigned addr,
                                     input int unsigned w,
                                     input int unsigned h);
    int unsigned col;
    int unsigned row;
    col = addr % w;
    row = addr / w;
    return (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
  endfunction

endpackage

// File: rtl/lbp_mem_responder_if.sv
// Bus bundle between the LBP engine/host side and lbp_mem_responder.
// The err signal exists only when LBP_RESP_CHECK_EN is defined.
interface lbp_mem_responder_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic [ADDR_W-1:0] gray_addr;
  logic              gray_req;
  logic              gray_ready;
  logic [7:0]        gray_data;
  logic [ADDR_W-1:0] lbp_addr;
  logic              lbp_valid;
  logic [7:0]        lbp_data;
  logic              finish;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_last;
  logic              done;
`ifdef LBP_RESP_CHECK_EN
  logic              err;
`endif

  modport slave (
    input  in_valid, in_data, gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data,
           finish, out_ready,
    output in_ready, gray_ready, gray_data, out_valid, out_data, out_last, done
`ifdef LBP_RESP_CHECK_EN
    , output err
`endif
  );

  modport master (
    output in_valid, in_data, gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data,
           finish, out_ready,
    input  in_ready, gray_ready, gray_data, out_valid, out_data, out_last, done
`ifdef LBP_RESP_CHECK_EN
    , input err
`endif
  );

endinterface

// File: rtl/lbp_img_ram.sv
// 2^ADDR_W x 8 image store: one synchronous write port, one asynchronous read port.
module lbp_img_ram #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lbp_mem_responder.sv
// Gray-image loader, engine read/write server and result dumper for the LBP system.
// Optional border/protocol checking (err output) is enabled by defining LBP_RESP_CHECK_EN.
module lbp_mem_responder
  import lbp_pkg::*;
#(
  parameter int unsigned IMG_W  = LBP_IMG_W,
  parameter int unsigned IMG_H  = LBP_IMG_H,
  parameter int unsigned ADDR_W = LBP_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  lbp_mem_responder_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  lbp_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [ADDR_W-1:0] dp_cnt_q, dp_cnt_d;
  logic              live_q;

  logic              in_ready;
  logic              in_fire;
  logic              lbp_fire;
  logic              out_fire;
  logic [7:0]        gray_rd;
  logic [7:0]        res_rd;
  logic              res_we;
  logic [ADDR_W-1:0] res_waddr;
  logic [7:0]        res_wdata;

  // live_q holds in_ready low for the first cycle after reset release.
  assign in_ready = (state_q == LOAD) && live_q;
  assign in_fire  = bus.in_valid && in_ready;
  assign lbp_fire = bus.lbp_valid && (state_q == SERVE);
  assign out_fire = (state_q == DUMP) && bus.out_ready;

  assign bus.in_ready   = in_ready;
  assign bus.gray_ready = (state_q == SERVE);
  assign bus.gray_data  = ((state_q == SERVE) && bus.gray_req) ? gray_rd : '0;
  assign bus.out_valid  = (state_q == DUMP);
  assign bus.out_data   = (state_q == DUMP) ? res_rd : '0;
  assign bus.out_last   = (state_q == DUMP) && (dp_cnt_q == LAST_ADDR);
  assign bus.done       = (state_q == DONE);

  // Result memory is cleared alongside the gray load so unwritten borders dump as 0.
  assign res_we    = in_fire || lbp_fire;
  assign res_waddr = in_fire ? ld_cnt_q : bus.lbp_addr;
  assign res_wdata = in_fire ? 8'h00 : bus.lbp_data;

  lbp_img_ram #(.ADDR_W(ADDR_W)) u_gray_mem (
    .clk     (clk),
    .we_i    (in_fire),
    .waddr_i (ld_cnt_q),
    .wdata_i (bus.in_data),
    .raddr_i (bus.gray_addr),
    .rdata_o (gray_rd)
  );

  lbp_img_ram #(.ADDR_W(ADDR_W)) u_res_mem (
    .clk     (clk),
    .we_i    (res_we),
    .waddr_i (res_waddr),
    .wdata_i (res_wdata),
    .raddr_i (dp_cnt_q),
    .rdata_o (res_rd)
  );

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    dp_cnt_d = dp_cnt_q;
    case (state_q)
      LOAD: begin
        if (in_fire) begin
          ld_cnt_d = ld_cnt_q + ADDR_W'(1);
          if (ld_cnt_q == LAST_ADDR) state_d = SERVE;
        end
      end
      SERVE: begin
        if (bus.finish) state_d = DUMP;
      end
      DUMP: begin
        if (out_fire) begin
          dp_cnt_d = dp_cnt_q + ADDR_W'(1);
          if (dp_cnt_q == LAST_ADDR) state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      ld_cnt_q <= '0;
      dp_cnt_q <= '0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      dp_cnt_q <= dp_cnt_d;
      live_q   <= 1'b1;
    end
  end

`ifdef LBP_RESP_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (lbp_fire && is_border(32'(bus.lbp_addr), IMG_W, IMG_H)) err_d = 1'b1;
    if (bus.gray_req && (state_q != SERVE)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err = err_q;
`endif

endmodule
